// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard logic
//
// Purpose: common definitions imported by hazard_unit and its helpers.
//   hz_state_t          vector-memory occupancy FSM states
//   REG_W_DEF           default register specifier width
//   VEC_MEM_CYCLES_DEF  default MEM-stage occupancy of one vector load/store
//   SCALAR_ZERO_REG     scalar register that is hardwired to zero
package pipeline_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    VEC_BUSY = 1'b1
  } hz_state_t;

  localparam int REG_W_DEF          = 5;
  localparam int VEC_MEM_CYCLES_DEF = 4;

  // Writes to scalar x0 are discarded, so a dependency on it is never real.
  localparam int SCALAR_ZERO_REG    = 0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// rtl/hazard_unit_sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose: counts single-cycle events, sticking at all-ones.
// Ports:
//   clk    in   pipeline clock (falling-edge active, like the segment registers)
//   rst    in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   clr    in   synchronous clear; wins over inc
//   count  out  current count
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      // An event coincident with a clear is dropped.
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush control for the IF/ID, ID/EX, EX/MEM, MEM/WB segments
//
// Purpose: inspects the control fields presented by the ID/EX and EX/MEM
// segments and drives their hold (stall) and bubble (flush) inputs for
// load-use hazards, multi-cycle vector memory ops and taken branches.
// Ports:
//   clk                          in   pipeline clock, state moves on the falling edge
//   rst                          in   asynchronous active-low reset
//   rs1_id, rs2_id               in   source specifiers of the ID instruction
//   use_rs1_id, use_rs2_id       in   ID instruction reads rs1 / rs2
//   src_vec_id                   in   ID sources are vector registers
//   RS3_ex                       in   destination specifier of the EX instruction
//   MemRead_ex                   in   EX instruction is a load
//   RegWriteS_ex, RegWriteV_ex   in   EX instruction writes a scalar / vector register
//   branch_taken_ex              in   branch resolved taken in EX
//   EnableRead_mem               in   vector load present in MEM
//   EnableWrite_mem              in   vector store present in MEM
//   perf_clr                     in   synchronous clear of both counters
//   stall_if, stall_id, stall_ex out  hold PC, IF/ID, ID/EX
//   flush_if_id, flush_id_ex,
//   flush_mem_wb                 out  bubble into the named segment
//   mem_busy                     out  vector op is holding MEM
//   stall_count, flush_count     out  saturating performance counters
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int VEC_MEM_CYCLES = VEC_MEM_CYCLES_DEF,
  parameter int REG_W          = REG_W_DEF,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             src_vec_id,
  input  logic [REG_W-1:0] RS3_ex,
  input  logic             MemRead_ex,
  input  logic             RegWriteS_ex,
  input  logic             RegWriteV_ex,
  input  logic             branch_taken_ex,
  input  logic             EnableRead_mem,
  input  logic             EnableWrite_mem,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_mem_wb,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  if ((VEC_MEM_CYCLES < 2) || (VEC_MEM_CYCLES > 255)) begin : g_bad_vec_cycles
    $error("hazard_unit: VEC_MEM_CYCLES must be in 2..255");
  end

  // The start cycle is already a stall, and the final (cnt==0) cycle is
  // not, so the counter covers the N-2 cycles in between.
  localparam logic [7:0] CNT_INIT = 8'(VEC_MEM_CYCLES - 2);

  hz_state_t  state;
  logic [7:0] cnt;

  logic vec_start;
  logic vec_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic class_ok;
  logic zero_dest;
  logic load_use;

  // ------------------------------------------------------------------
  // Vector memory occupancy
  // ------------------------------------------------------------------
  // vec_start only fires from IDLE, so an op still sitting in MEM while
  // VEC_BUSY cannot restart the window.
  assign vec_start = (state == IDLE) && (EnableRead_mem || EnableWrite_mem);
  assign vec_stall = vec_start || ((state == VEC_BUSY) && (cnt != 8'd0));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (vec_start) begin
            state <= VEC_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        VEC_BUSY: begin
          // At cnt==0 the held op leaves MEM on this edge.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Load-use detection
  // ------------------------------------------------------------------
  assign rs1_hit   = use_rs1_id && (rs1_id == RS3_ex);
  assign rs2_hit   = use_rs2_id && (rs2_id == RS3_ex);
  assign class_ok  = (RegWriteS_ex && !src_vec_id) || (RegWriteV_ex && src_vec_id);
  // Only the scalar file has a hardwired zero; vector register 0 is real.
  assign zero_dest = !src_vec_id && (RS3_ex == REG_W'(SCALAR_ZERO_REG));
  assign load_use  = MemRead_ex && (rs1_hit || rs2_hit) && class_ok && !zero_dest;

  // ------------------------------------------------------------------
  // Stall / flush priority
  // ------------------------------------------------------------------
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_mem_wb = 1'b0;
    mem_busy     = 1'b0;
    if (!rst) begin
      // Outputs stay quiet for the whole reset, whatever the inputs do.
    end else if (vec_stall) begin
      // EX is held, so a taken branch there is simply seen again on release.
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      stall_ex     = 1'b1;
      flush_mem_wb = 1'b1;
      mem_busy     = 1'b1;
    end else if (branch_taken_ex) begin
      // ID holds a wrong-path instruction, so its load-use hazard is moot.
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      // One bubble puts the load in MEM; forwarding handles the rest.
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Performance counters
  // ------------------------------------------------------------------
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if),
    .clr   (perf_clr),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if_id),
    .clr   (perf_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
module tb_hazard_unit;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_BR   = 7'b0001100;
  localparam logic [6:0] O_VEC  = 7'b1110011;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [4:0] rs1_id, rs2_id, RS3_ex;
  logic       use_rs1_id, use_rs2_id, src_vec_id;
  logic       MemRead_ex, RegWriteS_ex, RegWriteV_ex, branch_taken_ex;
  logic       EnableRead_mem, EnableWrite_mem, perf_clr;

  logic        st_if0, st_id0, st_ex0, fl_ifid0, fl_idex0, fl_memwb0, busy0;
  logic [31:0] sc0, fc0;
  logic        st_if1, st_id1, st_ex1, fl_ifid1, fl_idex1, fl_memwb1, busy1;
  logic [3:0]  sc1, fc1;

  hazard_unit #(.VEC_MEM_CYCLES(4), .REG_W(5), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst0),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .src_vec_id(src_vec_id), .RS3_ex(RS3_ex), .MemRead_ex(MemRead_ex),
    .RegWriteS_ex(RegWriteS_ex), .RegWriteV_ex(RegWriteV_ex),
    .branch_taken_ex(branch_taken_ex), .EnableRead_mem(EnableRead_mem),
    .EnableWrite_mem(EnableWrite_mem), .perf_clr(perf_clr),
    .stall_if(st_if0), .stall_id(st_id0), .stall_ex(st_ex0),
    .flush_if_id(fl_ifid0), .flush_id_ex(fl_idex0), .flush_mem_wb(fl_memwb0),
    .mem_busy(busy0), .stall_count(sc0), .flush_count(fc0)
  );

  hazard_unit #(.VEC_MEM_CYCLES(2), .REG_W(5), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .src_vec_id(src_vec_id), .RS3_ex(RS3_ex), .MemRead_ex(MemRead_ex),
    .RegWriteS_ex(RegWriteS_ex), .RegWriteV_ex(RegWriteV_ex),
    .branch_taken_ex(branch_taken_ex), .EnableRead_mem(EnableRead_mem),
    .EnableWrite_mem(EnableWrite_mem), .perf_clr(perf_clr),
    .stall_if(st_if1), .stall_id(st_id1), .stall_ex(st_ex1),
    .flush_if_id(fl_ifid1), .flush_id_ex(fl_idex1), .flush_mem_wb(fl_memwb1),
    .mem_busy(busy1), .stall_count(sc1), .flush_count(fc1)
  );

  logic [6:0] o0, o1;
  assign o0 = {st_if0, st_id0, st_ex0, fl_ifid0, fl_idex0, fl_memwb0, busy0};
  assign o1 = {st_if1, st_id1, st_ex1, fl_ifid1, fl_idex1, fl_memwb1, busy1};

  typedef struct {
    bit          sel;
    logic [6:0]  out;
    int unsigned sc;
    int unsigned fc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("out0",   e.id, {25'd0, o0}, {25'd0, e.out});
          chk("stall0", e.id, sc0, e.sc);
          chk("flush0", e.id, fc0, e.fc);
        end else begin
          chk("out1",   e.id, {25'd0, o1}, {25'd0, e.out});
          chk("stall1", e.id, {28'd0, sc1}, e.sc);
          chk("flush1", e.id, {28'd0, fc1}, e.fc);
        end
      end
    end
  end

  task automatic idle_in();
    rs1_id = '0; rs2_id = '0; RS3_ex = '0;
    use_rs1_id = 0; use_rs2_id = 0; src_vec_id = 0;
    MemRead_ex = 0; RegWriteS_ex = 0; RegWriteV_ex = 0; branch_taken_ex = 0;
    EnableRead_mem = 0; EnableWrite_mem = 0; perf_clr = 0;
  endtask

  task automatic lu_in();
    MemRead_ex = 1; RegWriteS_ex = 1; RS3_ex = 5'd7; rs1_id = 5'd7;
    use_rs1_id = 1; src_vec_id = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    idle_in();
  endtask

  task automatic expect_o(input bit sel, input logic [6:0] o, input int unsigned sc, input int unsigned fc);
    exp_t e;
    e.sel = sel; e.out = o; e.sc = sc; e.fc = fc; e.id = step_id;
    step_id++;
    q.push_back(e);
  endtask

  initial begin
    rst0 = 0; rst1 = 0;
    idle_in();

    // Reset holds outputs low even with a live hazard on the inputs.
    cyc(); lu_in(); expect_o(0, O_NONE, 0, 0);
    cyc(); rst0 = 1; expect_o(0, O_NONE, 0, 0);

    // Scalar load-use, then x0 and class-mismatch cases.
    cyc(); lu_in(); expect_o(0, O_LU, 0, 0);
    cyc(); expect_o(0, O_NONE, 1, 0);
    cyc(); lu_in(); RS3_ex = 5'd0; rs1_id = 5'd0; expect_o(0, O_NONE, 1, 0);
    cyc(); lu_in(); src_vec_id = 1; expect_o(0, O_NONE, 1, 0);
    // Vector register 0 through rs2 is a real dependency.
    cyc(); MemRead_ex = 1; RegWriteV_ex = 1; src_vec_id = 1; use_rs2_id = 1;
           rs2_id = 5'd0; RS3_ex = 5'd0; rs1_id = 5'd5; use_rs1_id = 1;
           expect_o(0, O_LU, 1, 0);
    cyc(); expect_o(0, O_NONE, 2, 0);

    // Vector load, 4-cycle occupancy: 3 stall cycles then release.
    for (int i = 0; i < 4; i++) begin
      cyc(); EnableRead_mem = 1;
      expect_o(0, (i < 3) ? O_VEC : O_NONE, 2 + i, 0);
    end
    cyc(); expect_o(0, O_NONE, 5, 0);

    // Branch beats load-use.
    cyc(); lu_in(); branch_taken_ex = 1; expect_o(0, O_BR, 5, 0);
    cyc(); expect_o(0, O_NONE, 5, 1);

    // Branch held in EX during a vector store flushes only on release.
    for (int i = 0; i < 4; i++) begin
      cyc(); EnableWrite_mem = 1; branch_taken_ex = 1;
      expect_o(0, (i < 3) ? O_VEC : O_BR, 5 + i, 1);
    end
    cyc(); expect_o(0, O_NONE, 8, 2);

    // Back-to-back vector ops: second starts right after the release cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(); EnableRead_mem = 1;
      expect_o(0, (i == 3 || i == 7) ? O_NONE : O_VEC, 8 + i - ((i >= 4) ? 1 : 0), 2);
    end
    cyc(); expect_o(0, O_NONE, 14, 2);

    // perf_clr beats a coincident event.
    cyc(); lu_in(); perf_clr = 1; expect_o(0, O_LU, 14, 2);
    cyc(); expect_o(0, O_NONE, 0, 0);
    cyc(); branch_taken_ex = 1; perf_clr = 1; expect_o(0, O_BR, 0, 0);
    cyc(); expect_o(0, O_NONE, 0, 0);

    // Reset asserted while VEC_BUSY with cnt=1.
    cyc(); EnableRead_mem = 1; expect_o(0, O_VEC, 0, 0);
    cyc(); EnableRead_mem = 1; expect_o(0, O_VEC, 1, 0);
    cyc(); EnableRead_mem = 1; rst0 = 0; expect_o(0, O_NONE, 0, 0);
    cyc(); rst0 = 1; expect_o(0, O_NONE, 0, 0);
    cyc(); expect_o(0, O_NONE, 0, 0);

    // Second instance: 2-cycle vector op and 4-bit counter saturation.
    cyc(); rst1 = 1; expect_o(1, O_NONE, 0, 0);
    cyc(); EnableRead_mem = 1; expect_o(1, O_VEC, 0, 0);
    cyc(); EnableRead_mem = 1; expect_o(1, O_NONE, 1, 0);
    cyc(); expect_o(1, O_NONE, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); lu_in();
      expect_o(1, O_LU, (i + 1 > 15) ? 15 : i + 1, 0);
    end
    cyc(); expect_o(1, O_NONE, 15, 0);
    cyc(); lu_in(); perf_clr = 1; expect_o(1, O_LU, 15, 0);
    cyc(); expect_o(1, O_NONE, 0, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer-side control for the pipeline segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Reads the control fields the ID/EX and EX/MEM segments present and drives their stall (hold) and flush (bubble) inputs.
- Covers three cases: one-cycle load-use bubbles, multi-cycle vector memory occupancy in MEM, and taken-branch flushes resolved in EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- VEC_MEM_CYCLES, 4, MEM-stage occupancy in cycles of one vector load/store (16 lanes x 16 bit); legal range 2..255.
- REG_W, 5, register specifier width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, the same edge the segment registers use.
- rst  in  1  reset, asynchronous, active-low.
- rs1_id, rs2_id  in  REG_W  source specifiers of the instruction in ID.
- use_rs1_id, use_rs2_id  in  1  ID instruction reads the rs1 / rs2 source.
- src_vec_id  in  1  ID sources are vector registers (0 = scalar).
- RS3_ex  in  REG_W  destination specifier of the instruction in EX.
- MemRead_ex, RegWriteS_ex, RegWriteV_ex  in  1  ID/EX control outputs.
- branch_taken_ex  in  1  branch resolved taken in EX.
- EnableRead_mem, EnableWrite_mem  in  1  vector memory op present in MEM.
- perf_clr  in  1  synchronous clear of both counters.
- stall_if, stall_id, stall_ex  out  1  hold PC, IF/ID and ID/EX respectively.
- flush_if_id, flush_id_ex, flush_mem_wb  out  1  load a bubble into the named segment.
- mem_busy  out  1  vector op holding MEM.
- stall_count, flush_count  out  CNT_W  performance counters.

Behaviour:
- State enum: IDLE, VEC_BUSY. Counter cnt is 8 bits.
- Reset: while rst=0, state=IDLE, cnt=0, both counters=0, and every stall/flush/mem_busy output is forced to 0 regardless of inputs. Reset takes effect immediately when asserted mid-operation.
- vec_start: state==IDLE and (EnableRead_mem or EnableWrite_mem).
- vec_stall: vec_start, or (state==VEC_BUSY and cnt!=0).
- vec_stall is Mealy, so it is asserted in the start cycle itself.
- IDLE -> VEC_BUSY on vec_start, with cnt <= VEC_MEM_CYCLES-2.
- VEC_BUSY: cnt decrements while cnt!=0. When cnt==0, return to IDLE with no stall that cycle; the held op advances at that edge.
- Stall timing: N-1 stall cycles per vector op. The still-present MEM op must not retrigger while in VEC_BUSY.
- Outputs while vec_stall=1: mem_busy=stall_if=stall_id=stall_ex=flush_mem_wb=1.
- load_use: MemRead_ex, and one of the following matches:
  - (use_rs1_id and rs1_id==RS3_ex), or
  - (use_rs2_id and rs2_id==RS3_ex),
  - and the register class agrees: RegWriteS_ex with src_vec_id=0, or RegWriteV_ex with src_vec_id=1.
  - Scalar register 0 never matches.
- Priority, per cycle, combinational:
  1. vec_stall: branch and load-use are both suppressed. EX is held, so the branch is re-seen once the stall releases.
  2. branch_taken_ex: flush_if_id=flush_id_ex=1, no stalls. Load-use is ignored because ID is on the wrong path.
  3. load_use: stall_if=stall_id=1, flush_id_ex=1, for exactly one cycle. The load then sits in MEM and forwarding covers it.
  4. Otherwise all outputs are 0.
- stall_count: +1 on each falling edge with stall_if=1.
- flush_count: +1 on each edge with a branch flush.
- Both counters saturate at all-ones. perf_clr has priority over increment.
- Counter events and perf_clr in the same cycle: the counter clears and the event is dropped.

Decomposition:
- pipeline_pkg holds:
  - hz_state_t {IDLE, VEC_BUSY};
  - the REG_W default;
  - the VEC_MEM_CYCLES default;
  - the scalar zero-register constant.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Reset during VEC_BUSY (cnt=1): rst low -> all outputs 0 immediately. After release with no vector op, state IDLE and no stall.
- Load-use: MemRead_ex=1, RegWriteS_ex=1, RS3_ex=7, rs1_id=7, use_rs1_id=1, src_vec_id=0 -> one cycle of stall_if=stall_id=flush_id_ex=1, stall_count=1. The same case with RS3_ex=0 -> no stall. The same case with src_vec_id=1 -> no stall.
- Vector load, VEC_MEM_CYCLES=4, EnableRead_mem held 4 cycles -> stalls plus flush_mem_wb on cycles 0-2, none on cycle 3, stall_count=3. Repeat with VEC_MEM_CYCLES=2 -> exactly 1 stall cycle.
- Branch with load-use simultaneously -> flush_if_id=flush_id_ex=1, stall_if=0, flush_count=1. Branch during vec_stall -> no flush until release, then one flush.
- Back-to-back vector ops (second arrives right after the cnt==0 cycle) -> two separate 3-cycle stall windows, mem_busy low for exactly one cycle between them.
- Counters: preload stall_count near all-ones via a long stall, then confirm saturation. perf_clr with an event in the same cycle -> counter reads 0.
